// File: rtl/programmable_pass_counter.sv
// Programmable terminal-count timer: one-shot or auto-reload, with pause on enable low,
// synchronous abort and a saturating tally of terminal hits per run.
module programmable_pass_counter #(
    parameter int WIDTH      = 8,
    parameter int PASS_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  enable,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      terminal,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [PASS_CNT_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [PASS_CNT_W-1:0] PASS_MAX = '1;

    state_t                state, state_nx;
    logic [WIDTH-1:0]      term_q, term_nx, count_nx;
    logic                  mode_q, mode_nx, pass_nx, done_nx;
    logic [PASS_CNT_W-1:0] pass_cnt_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            term_q   <= '0;
            mode_q   <= 1'b0;
            pass     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            pass_cnt <= '0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            term_q   <= term_nx;
            mode_q   <= mode_nx;
            pass     <= pass_nx;
            done     <= done_nx;
            busy     <= (state_nx == RUN);
            pass_cnt <= pass_cnt_nx;
        end
    end

    // Priority: abort over start over counting; enable low in RUN pauses without clearing.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        term_nx     = term_q;
        mode_nx     = mode_q;
        pass_nx     = 1'b0;
        done_nx     = done;
        pass_cnt_nx = pass_cnt;
        if (abort) begin
            state_nx    = IDLE;
            count_nx    = '0;
            done_nx     = 1'b0;
            pass_cnt_nx = '0;
        end else if (start) begin
            state_nx    = RUN;
            count_nx    = '0;
            done_nx     = 1'b0;
            pass_cnt_nx = '0;
            term_nx     = terminal;
            mode_nx     = auto_reload;
        end else if (state == RUN && enable) begin
            if (count == term_q) begin
                pass_nx = 1'b1;
                if (pass_cnt != PASS_MAX)
                    pass_cnt_nx = pass_cnt + 1'b1;
                if (mode_q) begin
                    count_nx = '0;
                end else begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end
            end else begin
                count_nx = count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_programmable_pass_counter.sv
// Randomised and directed bench; the reference model tracks enabled ticks since start
// and derives count/pass/tally arithmetically.
module tb_programmable_pass_counter;

    localparam int WIDTH      = 8;
    localparam int PASS_CNT_W = 4;
    localparam int PMAX       = (1 << PASS_CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start, enable, abort, auto_reload;
    logic [WIDTH-1:0]      terminal;
    logic [WIDTH-1:0]      count;
    logic                  busy, done, pass;
    logic [PASS_CNT_W-1:0] pass_cnt;

    int total = 0;
    int bad   = 0;

    // model: 0 idle, 1 run, 2 done
    int m_st, m_ticks, m_n, m_mode, m_pass;

    programmable_pass_counter #(.WIDTH(WIDTH), .PASS_CNT_W(PASS_CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .abort(abort),
        .terminal(terminal), .auto_reload(auto_reload), .count(count), .busy(busy),
        .done(done), .pass(pass), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_count();
        if (m_ticks == 0) return 0;
        if (m_mode != 0) return m_ticks % (m_n + 1);
        return (m_ticks < m_n) ? m_ticks : m_n;
    endfunction

    function automatic int exp_pcnt();
        int p;
        p = m_ticks / (m_n + 1);
        return (p > PMAX) ? PMAX : p;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ticks = 0; m_n = 0; m_mode = 0; m_pass = 0;
    endtask

    task automatic model_step(input logic s, a, e, input int t, input logic ar);
        m_pass = 0;
        if (a) begin
            m_st = 0; m_ticks = 0;
        end else if (s) begin
            m_st = 1; m_ticks = 0; m_n = t; m_mode = ar;
        end else if (m_st == 1 && e) begin
            m_pass = ((m_ticks % (m_n + 1)) == m_n) ? 1 : 0;
            m_ticks++;
            if (m_mode == 0 && m_pass == 1) m_st = 2;
        end
    endtask

    task automatic check_all();
        chk("count",    int'(count),    exp_count());
        chk("busy",     int'(busy),     (m_st == 1) ? 1 : 0);
        chk("done",     int'(done),     (m_st == 2) ? 1 : 0);
        chk("pass",     int'(pass),     m_pass);
        chk("pass_cnt", int'(pass_cnt), exp_pcnt());
    endtask

    task automatic cyc(input logic s, a, e, input int t, input logic ar);
        @(negedge clk);
        start = s; abort = a; enable = e; terminal = WIDTH'(t); auto_reload = ar;
        @(posedge clk);
        model_step(s, a, e, t, ar);
        #1;
        check_all();
    endtask

    initial begin
        int passes;
        reset = 1'b0; start = 0; abort = 0; enable = 0; terminal = '0; auto_reload = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;

        // reset asserted mid-run at count 3, N=7
        cyc(1, 0, 0, 7, 1);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("mid_count", int'(count), 3);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk); reset = 1'b1;
        cyc(0, 0, 1, 0, 0);
        chk("idle_busy", int'(busy), 0);

        // one-shot N=5: pass exactly once, then count holds at 5
        cyc(1, 0, 1, 5, 0);
        passes = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 9, 1);
            if (pass) begin
                chk("oneshot_lat", i + 1, 6);
                passes++;
            end
        end
        chk("oneshot_passes", passes, 1);
        chk("oneshot_count", int'(count), 5);
        chk("oneshot_done", int'(done), 1);

        // auto-reload N=3 for 20 cycles
        cyc(1, 0, 1, 3, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
        chk("auto_pcnt", int'(pass_cnt), 5);

        // pause at count 2, N=4
        cyc(1, 0, 1, 4, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("pause_hold", int'(count), 2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);

        // abort+start same edge, then start on the hit cycle
        cyc(1, 1, 1, 2, 1);
        chk("abort_wins", int'(busy), 0);
        cyc(1, 0, 1, 2, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 1, 6, 0);
        chk("start_on_hit", int'(pass), 0);

        // N=0 auto-reload: pass every cycle and tally saturates
        cyc(1, 0, 1, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
        chk("sat_pcnt", int'(pass_cnt), PMAX);

        // N=255 wrap
        cyc(1, 0, 1, 255, 1);
        for (int i = 0; i < 258; i++) cyc(0, 0, 1, 0, 0);
        chk("wrap_pcnt", int'(pass_cnt), 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int t;
            t = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 9));
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 3) != 0, t, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
